// File: rtl/led_display_mux.sv
// Time-multiplexed common-anode 7-segment driver: N digits, per-digit dp/blank, frame snapshot, dead time, PWM brightness.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module led_display_mux #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1600,
    parameter int DEAD_CYC   = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   tim,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            num,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int SLOT = CLK_HZ / REFRESH_HZ;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW   = CW + BRIGHT_W + 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] ACT_LEN   = PW'(SLOT - DEAD_CYC);
    localparam logic [CW:0]   DEAD      = (CW+1)'(DEAD_CYC);

    generate
        if (DIGITS < 1) begin : g_bad_digits
            $error("led_display_mux: DIGITS must be >= 1");
        end
        if (DEAD_CYC >= SLOT) begin : g_bad_dead
            $error("led_display_mux: DEAD_CYC must be smaller than the slot length");
        end
    endgenerate

    logic [CW-1:0]       slot_cnt_reg;
    logic [IW-1:0]       idx_reg;
    logic                frame_start_reg;
    logic [4*DIGITS-1:0] tim_q_reg;
    logic [DIGITS-1:0]   dp_q_reg;
    logic [DIGITS-1:0]   blank_q_reg;
    logic [CW:0]         on_len_reg;

    logic [PW-1:0]       bright_ext;
    logic [PW-1:0]       on_prod;
    logic [DIGITS-1:0]   suppress;
    logic [DIGITS-1:0]   dark_vec;
    logic [CW:0]         slot_ext;
    logic                lit_next;
    logic [3:0]          nib_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (slot_cnt_reg == SLOT_LAST) begin
            slot_cnt_reg <= '0;
            idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end else begin
            slot_cnt_reg <= slot_cnt_reg + CW'(1);
        end
    end

    // Pulse lags the (0,0) counter state by one cycle, so it also fires right after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= (slot_cnt_reg == '0) && (idx_reg == '0);
        end
    end

    assign bright_ext = PW'(bright) + PW'(1);
    assign on_prod    = ACT_LEN * bright_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            tim_q_reg   <= '0;
            dp_q_reg    <= '0;
            blank_q_reg <= '0;
            on_len_reg  <= '0;
        end else if (frame_start_reg) begin
            tim_q_reg   <= tim;
            dp_q_reg    <= dp_in;
            blank_q_reg <= blank;
            on_len_reg  <= on_prod[PW-1:BRIGHT_W];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero and carry no dp.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_d0
                assign suppress[gi] = 1'b0;
            end else begin : g_dn
                assign suppress[gi] = ~(|tim_q_reg[4*DIGITS-1:4*gi]) & ~(|dp_q_reg[DIGITS-1:gi]);
            end
        end
    endgenerate
`else
    assign suppress = '0;
`endif

    assign dark_vec = blank_q_reg | suppress;
    assign nib_sel  = tim_q_reg[{idx_reg, 2'b00} +: 4];

    always_comb begin
        slot_ext = {1'b0, slot_cnt_reg};
        lit_next = 1'b0;
        if ((slot_ext >= DEAD) && (slot_ext < DEAD + on_len_reg) && !dark_vec[idx_reg]) begin
            lit_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !lit_next) begin
            an  <= '1;
            num <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx_reg);
            num <= hex7(nib_sel);
            dp  <= ~dp_q_reg[idx_reg];
        end
    end

    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_led_display_mux.sv
// Directed bench for led_display_mux: frame-level vector table plus reset and timing sequences.
module tb_led_display_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tim;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [6:0]  num;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    led_display_mux #(
        .DIGITS(4), .CLK_HZ(32000), .REFRESH_HZ(1600), .DEAD_CYC(2), .BRIGHT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .tim(tim), .dp_in(dp_in), .blank(blank), .bright(bright),
        .an(an), .num(num), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     tim;
        logic [3:0]      dpi;
        logic [3:0]      blk;
        logic [3:0]      br;
        int              cnt[4];
        logic [6:0]      seg[4];
        logic [3:0]      dpl;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic [15:0] t, input logic [3:0] dpi,
                           input logic [3:0] blk, input logic [3:0] br,
                           input int c3, input int c2, input int c1, input int c0,
                           input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpl);
        vecs[k].tim = t;  vecs[k].dpi = dpi; vecs[k].blk = blk; vecs[k].br = br;
        vecs[k].cnt[3] = c3; vecs[k].cnt[2] = c2; vecs[k].cnt[1] = c1; vecs[k].cnt[0] = c0;
        vecs[k].seg[3] = s3; vecs[k].seg[2] = s2; vecs[k].seg[1] = s1; vecs[k].seg[0] = s0;
        vecs[k].dpl = dpl;
    endtask

    task automatic apply(input int k);
        tim = vecs[k].tim; dp_in = vecs[k].dpi; blank = vecs[k].blk; bright = vecs[k].br;
    endtask

    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s frame_start timeout actual=none required=pulse", name);
        end
    endtask

    // Observe one frame right after its frame_start; inputs switch to the next vector mid-frame.
    task automatic observe(input int k);
        int          cnt[4];
        int          first[4];
        logic [6:0]  seg[4];
        logic [3:0]  dpl;
        bit          dark_ok;
        int          d;
        for (int j = 0; j < 4; j++) begin
            cnt[j] = 0; first[j] = -1; seg[j] = 7'b1111111;
        end
        dpl = 4'b0000;
        dark_ok = 1'b1;
        for (int i = 0; i < 79; i++) begin
            @(posedge clk); #1;
            if (i == 0) apply((k + 1 < NV) ? k + 1 : k);
            case (an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (an === 4'b1111) begin
                if (num !== 7'b1111111 || dp !== 1'b1) dark_ok = 1'b0;
            end else if (d < 0) begin
                dark_ok = 1'b0;
            end else begin
                cnt[d]++;
                seg[d] = num;
                if (first[d] < 0) first[d] = i;
                if (dp === 1'b0) dpl[d] = 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("v%0d_cnt_d%0d", k, j), cnt[j], vecs[k].cnt[j]);
            chk($sformatf("v%0d_seg_d%0d", k, j), {25'd0, seg[j]}, {25'd0, vecs[k].seg[j]});
            chk($sformatf("v%0d_first_d%0d", k, j), first[j], (vecs[k].cnt[j] == 0) ? -1 : 20 * j + 1);
        end
        chk($sformatf("v%0d_dp_low", k), {28'd0, dpl}, {28'd0, vecs[k].dpl});
        chk($sformatf("v%0d_dark_clean", k), {31'd0, dark_ok}, 32'd1);
        $display("vector %0d tim=%h dp_in=%b blank=%b bright=%0d cnt=%0d/%0d/%0d/%0d",
                 k, vecs[k].tim, vecs[k].dpi, vecs[k].blk, vecs[k].br, cnt[3], cnt[2], cnt[1], cnt[0]);
    endtask

    initial begin
        int n;
        bit seen;
        // tim, dp_in, blank, bright, counts d3..d0, segments d3..d0, dp-low mask
        set_vec(0, 16'h12AF, 4'b0000, 4'b0000, 4'd15, 18, 18, 18, 18,
                7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000, 4'b0000);
        set_vec(1, 16'h12AF, 4'b0000, 4'b0000, 4'd7, 9, 9, 9, 9,
                7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000, 4'b0000);
        set_vec(2, 16'h12AF, 4'b0000, 4'b0000, 4'd0, 1, 1, 1, 1,
                7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000, 4'b0000);
        set_vec(3, 16'h12AF, 4'b0001, 4'b0100, 4'd15, 18, 0, 18, 18,
                7'b1001111, 7'b1111111, 7'b0001000, 7'b0111000, 4'b0001);
`ifdef LEADING_ZERO_BLANK_EN
        set_vec(4, 16'h0030, 4'b0000, 4'b0000, 4'd15, 0, 0, 18, 18,
                7'b1111111, 7'b1111111, 7'b0000110, 7'b0000001, 4'b0000);
        set_vec(5, 16'h0000, 4'b0100, 4'b0000, 4'd15, 0, 18, 18, 18,
                7'b1111111, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0100);
`else
        set_vec(4, 16'h0030, 4'b0000, 4'b0000, 4'd15, 18, 18, 18, 18,
                7'b0000001, 7'b0000001, 7'b0000110, 7'b0000001, 4'b0000);
        set_vec(5, 16'h0000, 4'b0100, 4'b0000, 4'd15, 18, 18, 18, 18,
                7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0100);
`endif
        set_vec(6, 16'h8E5C, 4'b0000, 4'b0000, 4'd3, 4, 4, 4, 4,
                7'b0000000, 7'b0110000, 7'b0100100, 7'b0110001, 4'b0000);
        set_vec(7, 16'h3B64, 4'b1010, 4'b0000, 4'd11, 13, 13, 13, 13,
                7'b0000110, 7'b1100000, 7'b0100000, 7'b1001100, 4'b1010);

        rst = 1'b1;
        apply(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_num", {25'd0, num}, 32'h7F);
        chk("reset_dp", {31'd0, dp}, 32'd1);
        chk("reset_frame_start", {31'd0, frame_start}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("release_frame_start", {31'd0, frame_start}, 32'd1);
        seen = 1'b0;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (frame_start === 1'b1) begin
                n = c;
                seen = 1'b1;
                break;
            end
        end
        chk("frame_period", n, 80);
        $display("reset sequence: frame period %0d cycles (found=%0d)", n, seen);

        for (int k = 0; k < NV; k++) begin
            wait_frame($sformatf("v%0d", k));
            observe(k);
        end

        // Reset asserted while digit 2 is lit: dark next cycle, scan restarts at digit 0.
        apply(0);
        wait_frame("rst_mid");
        repeat (45) @(posedge clk);
        #1;
        chk("mid_slot2_an", {28'd0, an}, 32'hB);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_num", {25'd0, num}, 32'h7F);
        chk("mid_rst_dp", {31'd0, dp}, 32'd1);
        chk("mid_rst_frame_start", {31'd0, frame_start}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("restart_frame_start", {31'd0, frame_start}, 32'd1);
        @(posedge clk); #1;
        chk("restart_dead_an", {28'd0, an}, 32'hF);
        @(posedge clk); #1;
        chk("restart_d0_an", {28'd0, an}, 32'hE);
        chk("restart_d0_num", {25'd0, num}, {25'd0, 7'b0111000});
        $display("mid-frame reset sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
